// File: rtl/lock_entry_sequencer.sv
// One unlock attempt on the combination lock: buffers entered digits, compares them in
// constant time against the password store, counts failures and enforces a timed lockout.
module lock_entry_sequencer #(
   parameter int DIGIT_W        = 4,
   parameter int MAX_LEN        = 8,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 50000000,
   localparam int LEN_W         = $clog2(MAX_LEN + 1),
   localparam int ADDR_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic               clk,
   input  logic               system_reset,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               submit,
   input  logic               clear,
   input  logic [LEN_W-1:0]   pass_len,
   output logic               pass_rd_en,
   output logic [ADDR_W-1:0]  pass_addr,
   input  logic [DIGIT_W-1:0] pass_data,
   output logic               busy,
   output logic               unlock,
   output logic               fail,
   output logic               locked_out,
   output logic [1:0]         attempts,
   output logic [LEN_W-1:0]   entry_count,
   output logic [3:0]         state_code
);

   localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ENTRY   = 4'd1,
      S_COMPARE = 4'd2,
      S_RESULT  = 4'd3,
      S_LOCKOUT = 4'd4
   } state_t;

   state_t             state_q;
   logic [DIGIT_W-1:0] buf_q [MAX_LEN];
   logic [LEN_W-1:0]   entry_count_q;
   logic               overflow_q;
   logic               mismatch_q;
   logic [LEN_W-1:0]   len_n_q;
   logic [LEN_W-1:0]   cyc_q;
   logic [CNT_W-1:0]   lock_cnt_q;
   logic [1:0]         attempts_q;
   logic               pass_rd_en_q;
   logic [ADDR_W-1:0]  pass_addr_q;
   logic               busy_q;
   logic               unlock_q;
   logic               fail_q;
   logic               locked_out_q;

   logic               entry_full;
   logic               digit_take;
   logic [LEN_W-1:0]   entry_count_d;
   logic               overflow_d;
   logic [LEN_W-1:0]   len_n_d;
   logic               mismatch_d;
   logic [ADDR_W-1:0]  rd_idx;
   logic               data_diff;
   logic               cmp_mismatch_d;
   logic [1:0]         attempts_d;

   // Entry bookkeeping, mismatch preset and per-cycle digit compare
   always_comb begin
      entry_full     = (entry_count_q == LEN_W'(MAX_LEN));
      digit_take     = digit_valid && !entry_full;
      entry_count_d  = digit_take ? (entry_count_q + 1'b1) : entry_count_q;
      overflow_d     = overflow_q | (digit_valid & entry_full);
      len_n_d        = (pass_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pass_len;
      mismatch_d     = (entry_count_d != pass_len) | overflow_d |
                       (pass_len == {LEN_W{1'b0}}) | (pass_len > LEN_W'(MAX_LEN));
      // Read data arriving in compare cycle k belongs to the address issued in cycle k-1
      rd_idx         = ADDR_W'(cyc_q - 1'b1);
      data_diff      = (cyc_q != {LEN_W{1'b0}}) && (pass_data != buf_q[rd_idx]);
      cmp_mismatch_d = mismatch_q | data_diff;
      if (!cmp_mismatch_d) begin
         attempts_d = 2'd0;
      end else if (attempts_q == 2'd3) begin
         attempts_d = 2'd3;
      end else begin
         attempts_d = attempts_q + 2'd1;
      end
   end

   // Attempt sequencer with registered outputs
   always_ff @(posedge clk or posedge system_reset) begin
      if (system_reset) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= {DIGIT_W{1'b0}};
         entry_count_q <= {LEN_W{1'b0}};
         overflow_q    <= 1'b0;
         mismatch_q    <= 1'b0;
         len_n_q       <= {LEN_W{1'b0}};
         cyc_q         <= {LEN_W{1'b0}};
         lock_cnt_q    <= {CNT_W{1'b0}};
         attempts_q    <= 2'd0;
         pass_rd_en_q  <= 1'b0;
         pass_addr_q   <= {ADDR_W{1'b0}};
         busy_q        <= 1'b0;
         unlock_q      <= 1'b0;
         fail_q        <= 1'b0;
         locked_out_q  <= 1'b0;
      end else begin
         unlock_q <= 1'b0;
         fail_q   <= 1'b0;
         case (state_q)
            S_IDLE, S_ENTRY: begin
               if (clear) begin
                  state_q       <= S_IDLE;
                  entry_count_q <= {LEN_W{1'b0}};
                  overflow_q    <= 1'b0;
               end else begin
                  if (digit_take) buf_q[entry_count_q[ADDR_W-1:0]] <= digit_in;
                  entry_count_q <= entry_count_d;
                  overflow_q    <= overflow_d;
                  if (submit) begin
                     state_q      <= S_COMPARE;
                     busy_q       <= 1'b1;
                     mismatch_q   <= mismatch_d;
                     len_n_q      <= len_n_d;
                     cyc_q        <= {LEN_W{1'b0}};
                     pass_rd_en_q <= (len_n_d != {LEN_W{1'b0}});
                     pass_addr_q  <= {ADDR_W{1'b0}};
                  end else if (digit_valid) begin
                     state_q <= S_ENTRY;
                  end else begin
                     state_q <= state_q;
                  end
               end
            end
            S_COMPARE: begin
               mismatch_q <= cmp_mismatch_d;
               cyc_q      <= cyc_q + 1'b1;
               // Always runs len_n_q+1 cycles so timing never depends on where a mismatch sits
               if (cyc_q == len_n_q) begin
                  state_q      <= S_RESULT;
                  pass_rd_en_q <= 1'b0;
                  pass_addr_q  <= {ADDR_W{1'b0}};
                  unlock_q     <= !cmp_mismatch_d;
                  fail_q       <= cmp_mismatch_d;
                  attempts_q   <= attempts_d;
               end else if ((cyc_q + 1'b1) < len_n_q) begin
                  pass_rd_en_q <= 1'b1;
                  pass_addr_q  <= ADDR_W'(cyc_q + 1'b1);
               end else begin
                  pass_rd_en_q <= 1'b0;
               end
            end
            S_RESULT: begin
               entry_count_q <= {LEN_W{1'b0}};
               overflow_q    <= 1'b0;
               if (int'(attempts_q) >= MAX_ATTEMPTS) begin
                  state_q      <= S_LOCKOUT;
                  locked_out_q <= 1'b1;
                  lock_cnt_q   <= CNT_W'(LOCKOUT_CYCLES - 1);
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_LOCKOUT: begin
               if (lock_cnt_q == {CNT_W{1'b0}}) begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  locked_out_q <= 1'b0;
                  attempts_q   <= 2'd0;
               end else begin
                  lock_cnt_q <= lock_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               busy_q       <= 1'b0;
               locked_out_q <= 1'b0;
               pass_rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign pass_rd_en  = pass_rd_en_q;
   assign pass_addr   = pass_addr_q;
   assign busy        = busy_q;
   assign unlock      = unlock_q;
   assign fail        = fail_q;
   assign locked_out  = locked_out_q;
   assign attempts    = attempts_q;
   assign entry_count = entry_count_q;
   assign state_code  = state_q;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Bench for lock_entry_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized attempts.
module tb_lock_entry_sequencer;
   localparam int ML   = 8;
   localparam int MA   = 3;
   localparam int LOCK = 10;

   logic       clk = 1'b0;
   logic       system_reset = 1'b1;
   logic       digit_valid = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       submit = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] pass_len = 4'd0;
   logic       pass_rd_en;
   logic [2:0] pass_addr;
   logic [3:0] pass_data = 4'd0;
   logic       busy, unlock, fail, locked_out;
   logic [1:0] attempts;
   logic [3:0] entry_count;
   logic [3:0] state_code;
   logic [3:0] mem [8];

   lock_entry_sequencer #(.DIGIT_W(4), .MAX_LEN(ML), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LOCK)) dut (
      .clk(clk), .system_reset(system_reset), .digit_valid(digit_valid), .digit_in(digit_in),
      .submit(submit), .clear(clear), .pass_len(pass_len), .pass_rd_en(pass_rd_en),
      .pass_addr(pass_addr), .pass_data(pass_data), .busy(busy), .unlock(unlock), .fail(fail),
      .locked_out(locked_out), .attempts(attempts), .entry_count(entry_count), .state_code(state_code));

   always #5 clk = ~clk;

   // Password store: registered read, data valid the cycle after the enable
   always @(posedge clk) if (pass_rd_en) pass_data <= mem[pass_addr];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: entered digits, failure count, and the time window of the current attempt
   int m_ent[$];
   bit m_ovf, m_act, m_match, m_lock;
   int m_att, m_cs, m_res, m_n;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int busy_end();
      return m_lock ? m_res + LOCK : m_res;
   endfunction

   function automatic bit in_win();
      return m_act && cyc >= m_cs && cyc <= busy_end();
   endfunction

   task automatic model_reset();
      m_ent.delete();
      m_ovf = 0; m_act = 0; m_match = 0; m_lock = 0;
      m_att = 0; m_cs = 0; m_res = 0; m_n = 0;
   endtask

   task automatic model_events();
      if (m_act && cyc == m_res) begin
         if (m_match) m_att = 0;
         else if (m_att < 3) m_att++;
         m_lock = (m_att >= MA);
      end
      if (m_act && cyc == m_res + 1) begin
         m_ent.delete();
         m_ovf = 0;
      end
      if (m_act && m_lock && cyc == m_res + LOCK + 1) m_att = 0;
      if (m_act && cyc > busy_end()) m_act = 0;
   endtask

   task automatic model_compare();
      bit w, e_rd;
      int e_state;
      w = in_win();
      e_rd = w && (cyc < m_cs + m_n);
      if (!w) e_state = (m_ent.size() > 0) ? 1 : 0;
      else if (cyc < m_res) e_state = 2;
      else if (cyc == m_res) e_state = 3;
      else e_state = 4;
      chk("busy", int'(busy), int'(w));
      chk("unlock", int'(unlock), int'(w && cyc == m_res && m_match));
      chk("fail", int'(fail), int'(w && cyc == m_res && !m_match));
      chk("locked_out", int'(locked_out), int'(w && cyc > m_res));
      chk("attempts", int'(attempts), m_att);
      chk("entry_count", int'(entry_count), m_ent.size());
      chk("state_code", int'(state_code), e_state);
      chk("pass_rd_en", int'(pass_rd_en), int'(e_rd));
      if (e_rd) chk("pass_addr", int'(pass_addr), cyc - m_cs);
   endtask

   task automatic model_apply();
      int pl;
      if (!in_win()) begin
         if (clear) begin
            m_ent.delete();
            m_ovf = 0;
         end else begin
            if (digit_valid) begin
               if (m_ent.size() < ML) m_ent.push_back(int'(digit_in));
               else m_ovf = 1;
            end
            if (submit) begin
               pl = int'(pass_len);
               m_n = (pl > ML) ? ML : pl;
               m_cs = cyc + 1;
               m_res = cyc + m_n + 2;
               m_lock = 0;
               m_act = 1;
               m_match = !m_ovf && m_ent.size() == pl && pl >= 1 && pl <= ML;
               if (m_match) foreach (m_ent[i]) if (m_ent[i] != int'(mem[i])) m_match = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_events();
      model_compare();
   endtask

   task automatic cyc_in(input bit dv, input int d, input bit sb, input bit cl);
      tick();
      digit_valid = dv;
      digit_in = 4'(d);
      submit = sb;
      clear = cl;
      model_apply();
   endtask

   task automatic noise();
      int r;
      tick();
      r = $urandom_range(0, 7);
      digit_valid = (r == 1 || r == 4);
      submit = (r == 2 || r == 4 || r == 5);
      clear = (r == 3 || r == 5);
      digit_in = 4'($urandom_range(0, 15));
      pass_len = 4'($urandom_range(0, 15));
      model_apply();
   endtask

   task automatic enter(input int ds[$]);
      foreach (ds[i]) cyc_in(1, ds[i], 0, 0);
   endtask

   // Submit, then expect the result pulse exactly lat cycles later and nothing before
   task automatic directed_attempt(input string nm, input bit exp_unlock, input int exp_att, input int lat);
      cyc_in(0, 0, 1, 0);
      for (int k = 1; k <= lat; k++) begin
         cyc_in(0, 0, 0, 0);
         if (k < lat) chk({nm, "_early"}, int'(unlock | fail), 0);
         if (k == lat) begin
            chk({nm, "_unlock"}, int'(unlock), int'(exp_unlock));
            chk({nm, "_fail"}, int'(fail), int'(!exp_unlock));
            chk({nm, "_attempts"}, int'(attempts), exp_att);
         end
      end
   endtask

   task automatic mid_reset(input string nm);
      #2;
      system_reset = 1'b1;
      #1;
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_locked"}, int'(locked_out), 0);
      chk({nm, "_unlock_fail"}, int'(unlock | fail), 0);
      chk({nm, "_attempts"}, int'(attempts), 0);
      chk({nm, "_entry"}, int'(entry_count), 0);
      chk({nm, "_state"}, int'(state_code), 0);
      chk({nm, "_rd_en"}, int'(pass_rd_en), 0);
      @(posedge clk);
      #1;
      system_reset = 1'b0;
      digit_valid = 1'b0; submit = 1'b0; clear = 1'b0;
      model_reset();
      cyc_in(0, 0, 0, 0);
      chk({nm, "_post_state"}, int'(state_code), 0);
      chk({nm, "_post_att"}, int'(attempts), 0);
   endtask

   task automatic rand_attempt();
      int pl, n8, mode, lo;
      int ent[$];
      for (int i = 0; i < 40 && m_act; i++) cyc_in(0, 0, 0, 0);
      cyc_in(0, 0, 0, 1);
      mode = $urandom_range(0, 19);
      if (mode == 0) pl = 0;
      else if (mode == 1) pl = $urandom_range(9, 15);
      else pl = $urandom_range(1, 8);
      pass_len = 4'(pl);
      for (int i = 0; i < 8; i++) mem[i] = 4'($urandom_range(0, 15));
      n8 = (pl > ML) ? ML : pl;
      mode = $urandom_range(0, 3);
      if (mode == 3) begin
         lo = $urandom_range(0, 10);
         for (int i = 0; i < lo; i++) ent.push_back($urandom_range(0, 15));
      end else begin
         for (int i = 0; i < n8; i++) ent.push_back(int'(mem[i]));
         if (mode == 2 && n8 > 0) begin
            lo = $urandom_range(0, n8 - 1);
            ent[lo] = (ent[lo] + $urandom_range(1, 15)) % 16;
         end
      end
      if ($urandom_range(0, 3) == 0) begin
         cyc_in(1, $urandom_range(0, 15), 0, 0);
         cyc_in(0, 0, 0, 1);
      end
      lo = $urandom_range(0, 2);
      foreach (ent[i]) begin
         if ($urandom_range(0, 2) == 0) cyc_in(0, 0, 0, 0);
         cyc_in(1, ent[i], (i == ent.size() - 1) && lo == 0, 0);
      end
      if (lo != 0 || ent.size() == 0) cyc_in(0, 0, 1, 0);
      for (int i = 0; i < 40 && m_act; i++) noise();
   endtask

   initial begin
      int lo_cnt;
      model_reset();
      for (int i = 0; i < 8; i++) mem[i] = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_state", int'(state_code), 0);
      chk("rst_attempts", int'(attempts), 0);
      chk("rst_entry", int'(entry_count), 0);
      chk("rst_rd_en", int'(pass_rd_en), 0);
      system_reset = 1'b0;

      // Correct password 1,2,3,4
      pass_len = 4'd4;
      mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd4;
      enter('{1, 2, 3, 4});
      cyc_in(0, 0, 1, 0);
      for (int k = 1; k <= 7; k++) begin
         cyc_in(0, 0, 0, 0);
         if (k <= 4) begin
            chk("d1_rd_en", int'(pass_rd_en), 1);
            chk("d1_addr", int'(pass_addr), k - 1);
         end
         if (k == 6) begin
            chk("d1_unlock", int'(unlock), 1);
            chk("d1_attempts", int'(attempts), 0);
         end
         if (k == 7) chk("d1_state", int'(state_code), 0);
      end

      enter('{1, 2, 3, 5});
      directed_attempt("d2", 0, 1, 6);
      enter('{1, 2, 3});
      directed_attempt("d3", 0, 2, 6);
      enter('{4, 4, 4, 4});
      directed_attempt("d4", 0, 3, 6);
      lo_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (in_win()) noise();
         else cyc_in(0, 0, 0, 0);
         if (locked_out) lo_cnt++;
      end
      chk("d4_lock_len", lo_cnt, 10);
      chk("d4_att_after", int'(attempts), 0);
      chk("d4_state_after", int'(state_code), 0);

      // Overflow: nine digits against an eight-digit password
      pass_len = 4'd8;
      for (int i = 0; i < 8; i++) mem[i] = 4'(i + 1);
      cyc_in(0, 0, 0, 1);
      enter('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      cyc_in(0, 0, 0, 0);
      chk("d5_entry_sat", int'(entry_count), 8);
      directed_attempt("d5", 0, 1, 10);

      // Clear, and clear winning over submit
      enter('{1, 2});
      cyc_in(0, 0, 0, 1);
      cyc_in(0, 0, 0, 0);
      chk("d6_entry", int'(entry_count), 0);
      chk("d6_att", int'(attempts), 1);
      enter('{3});
      cyc_in(0, 0, 1, 1);
      cyc_in(0, 0, 0, 0);
      chk("d6_cs_state", int'(state_code), 0);
      chk("d6_cs_busy", int'(busy), 0);
      chk("d6_cs_entry", int'(entry_count), 0);

      // Zero-length password
      pass_len = 4'd0;
      cyc_in(0, 0, 1, 0);
      cyc_in(0, 0, 0, 0);
      chk("d7_state", int'(state_code), 2);
      chk("d7_rd_en", int'(pass_rd_en), 0);
      cyc_in(0, 0, 0, 0);
      chk("d7_fail", int'(fail), 1);
      chk("d7_att", int'(attempts), 2);

      // Reset mid-compare
      pass_len = 4'd4;
      cyc_in(0, 0, 0, 0);
      enter('{1, 2, 3, 4});
      cyc_in(0, 0, 1, 0);
      cyc_in(0, 0, 0, 0);
      cyc_in(0, 0, 0, 0);
      mid_reset("d8");

      // Reset mid-lockout
      pass_len = 4'd0;
      for (int a = 0; a < 3; a++) begin
         cyc_in(0, 0, 1, 0);
         cyc_in(0, 0, 0, 0);
         cyc_in(0, 0, 0, 0);
      end
      repeat (3) cyc_in(0, 0, 0, 0);
      chk("d9_locked", int'(locked_out), 1);
      mid_reset("d9");

      for (int n = 0; n < 200; n++) rand_attempt();
      for (int i = 0; i < 40 && m_act; i++) cyc_in(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lock_entry_sequencer.md
Name: lock_entry_sequencer

Overview:
Sequences one unlock attempt on the combination-lock datapath. Buffers digits entered by the user and, on submit, reads the stored password digit by digit from the setup panel's password store. Compares in constant time, reports unlock or fail, and enforces an attempt limit with a timed lockout. Sits between the top-level button/keypad logic and the password store, replacing ad-hoc attempt counting in the top controller.

Parameters:
DIGIT_W, 4, bits per digit.
MAX_LEN, 8, maximum password/entry length in digits; LEN_W = clog2(MAX_LEN+1).
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (≥1).
LOCKOUT_CYCLES, 50000000, lockout duration in clk cycles (≥1).

Ports:
clk  in  1  system clock; all state on rising edge.
system_reset  in  1  asynchronous, active-high reset.
digit_valid  in  1  one-cycle strobe: digit_in is a new entered digit.
digit_in  in  DIGIT_W  entered digit value.
submit  in  1  one-cycle strobe: end entry, start compare.
clear  in  1  one-cycle strobe: discard current entry.
pass_len  in  LEN_W  stored password length, from setup panel.
pass_rd_en  out  1  read enable to password store.
pass_addr  out  clog2(MAX_LEN)  digit index being read.
pass_data  in  DIGIT_W  read data, valid the cycle after pass_rd_en.
busy  out  1  high in COMPARE, RESULT, LOCKOUT.
unlock  out  1  one-cycle pulse on match.
fail  out  1  one-cycle pulse on mismatch.
locked_out  out  1  high throughout LOCKOUT.
attempts  out  2  consecutive failure count, saturating at 3.
entry_count  out  LEN_W  digits currently buffered.
state_code  out  4  IDLE=0, ENTRY=1, COMPARE=2, RESULT=3, LOCKOUT=4; drives hex display.

Behaviour:
- Reset (asynchronous, any state including mid-compare or lockout): state IDLE; all outputs 0; buffer, attempts, mismatch flag, lockout counter cleared.
- IDLE: digit_valid → store digit at index 0, entry_count=1, go to ENTRY. submit → COMPARE with entry_count=0. clear is a no-op.
- ENTRY: each digit_valid writes buffer[entry_count] and increments it. Digits beyond MAX_LEN are dropped and set overflow, which forces a mismatch. digit_valid and submit in the same cycle: the digit is accepted first, then COMPARE. clear → IDLE with entry_count=0 and overflow=0; attempts unchanged. clear and submit in the same cycle: clear wins.
- COMPARE: the mismatch flag is preset to (entry_count≠pass_len) | overflow | (pass_len==0) | (pass_len>MAX_LEN).
  - Cycles k = 0..N-1, with N = min(pass_len, MAX_LEN): pass_rd_en=1, pass_addr=k.
  - In cycle k+1, pass_data is compared with buffer[k]; any difference sets mismatch.
  - No early exit: COMPARE lasts N+1 cycles regardless of outcome (1 cycle if N=0).
  - digit_valid, submit and clear are ignored.
- RESULT (1 cycle):
  - Match: unlock=1, attempts←0.
  - Otherwise: fail=1, attempts←min(attempts+1,3).
  - Next state: LOCKOUT if the new attempts ≥ MAX_ATTEMPTS, else IDLE.
  - entry_count←0 on exit.
- LOCKOUT:
  - On entry the counter is loaded with LOCKOUT_CYCLES-1 and decrements every cycle; locked_out=1; all inputs ignored.
  - When the counter is 0 and the state is LOCKOUT: → IDLE and attempts←0.
  - Total lockout = LOCKOUT_CYCLES cycles.
- Latency: submit on cycle t → unlock/fail asserted on cycle t+N+2.
- All outputs are registered. pass_len is sampled once, on the cycle submit is accepted, and held through COMPARE.

Test Plan:
- Password 1,2,3,4 (pass_len=4); enter 1,2,3,4, submit at t → pass_addr 0..3 on t+1..t+4, unlock=1 on t+6, attempts=0, state back to 0.
- Enter 1,2,3,5 → fail on t+6, attempts=1. Enter 1,2,3 → fail at the same latency (constant time), attempts=2.
- Third failure with MAX_ATTEMPTS=3 and LOCKOUT_CYCLES=10 → locked_out high for exactly 10 cycles; digits and submits ignored throughout; then attempts=0, state 0.
- Enter 9 digits with MAX_LEN=8 → entry_count stays 8 and the attempt fails. Enter 1,2 then clear → entry_count=0 and attempts unchanged; clear+submit in the same cycle → IDLE with no compare.
- pass_len=0 and submit from IDLE → 1-cycle COMPARE, then fail, with no pass_rd_en pulse.
- Assert system_reset mid-COMPARE and mid-LOCKOUT → outputs 0 immediately (asynchronous); after release, state 0 and attempts 0.
